// File: rtl/irq_sequencer_if.sv
// irq_sequencer_if: request, register-write, pipeline-control and dispatch signals of the sequencer
// Latency: none (wires only)
// Backpressure: pipe_empty from the pipeline holds the sequencer in its drain wait
interface irq_sequencer_if #(
   parameter int NUM_IRQ = 8
);
   logic [NUM_IRQ-1:0] irq;
   logic               gie_we;
   logic               gie_wdata;
   logic               mask_we;
   logic [NUM_IRQ-1:0] mask_wdata;
   logic               pipe_empty;
   logic [31:0]        resume_pc;
   logic               rti;
   logic               stall;
   logic               flush;
   logic               ilr_we;
   logic [31:0]        ilr_wdata;
   logic               vec_valid;
   logic [31:0]        vec_pc;
   logic               in_isr;
   logic [4:0]         irq_id;
   logic [NUM_IRQ-1:0] pending;

   // pipeline / register-file side
   modport master (
      output irq, gie_we, gie_wdata, mask_we, mask_wdata, pipe_empty, resume_pc, rti,
      input  stall, flush, ilr_we, ilr_wdata, vec_valid, vec_pc, in_isr, irq_id, pending
   );

   // sequencer side
   modport slave (
      input  irq, gie_we, gie_wdata, mask_we, mask_wdata, pipe_empty, resume_pc, rti,
      output stall, flush, ilr_we, ilr_wdata, vec_valid, vec_pc, in_isr, irq_id, pending
   );
endinterface

// File: rtl/irq_sequencer.sv
// irq_sequencer: synchronise/latch IRQ lines, dispatch highest-priority enabled one (IRQ_EDGE_EN = edge-triggered pending)
// Latency: irq->pending 2 cycles (+1 edge mode); pending->stall +1, ILR write +2, vector +3, handler +4
// Backpressure: waits in DRAIN while pipe_empty is low; abandons the dispatch if the request disappears
module irq_sequencer #(
   parameter int          NUM_IRQ    = 8,
   parameter logic [31:0] VEC_BASE   = 32'h0000_0100,
   parameter logic [31:0] VEC_STRIDE = 32'h0000_0010
) (
   input logic            clk,
   input logic            rst_n,
   irq_sequencer_if.slave bus
);

   typedef enum logic [2:0] {IDLE, DRAIN, SAVE, VECTOR, ISR} state_t;

   state_t             state;
   logic [NUM_IRQ-1:0] sync1, sirq;
   logic [NUM_IRQ-1:0] set_vec, pending_q, pending_set, mask_q, mask_nxt, req;
   logic               gie_q, gie_nxt, req_go, req_go_nxt;
   logic [4:0]         sel, irq_id_q;
   logic               stall_q, flush_q, ilr_we_q, vec_valid_q, in_isr_q;
   logic [31:0]        vec_pc_q;

   // two-flop synchroniser for the asynchronous request lines
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1 <= '0;
         sirq  <= '0;
      end else begin
         sync1 <= bus.irq;
         sirq  <= sync1;
      end
   end

`ifdef IRQ_EDGE_EN
   logic [NUM_IRQ-1:0] sirq_d, edge_q;

   // registered rising-edge detect: a held-high line yields a single set pulse
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sirq_d <= '0;
         edge_q <= '0;
      end else begin
         sirq_d <= sirq;
         edge_q <= sirq & ~sirq_d;
      end
   end

   assign set_vec = edge_q;
`else
   assign set_vec = sirq;
`endif

   // request qualification, next-cycle register values and priority pick (index 0 wins)
   always_comb begin
      pending_set = pending_q | set_vec;
      mask_nxt    = bus.mask_we ? bus.mask_wdata : mask_q;
      gie_nxt     = bus.gie_we ? bus.gie_wdata : gie_q;
      req         = pending_q & mask_q;
      req_go      = gie_q & (|req);
      // what req_go will be next cycle: lets the SAVE-cycle ILR strobe be a plain register
      req_go_nxt  = gie_nxt & (|(pending_set & mask_nxt));
      sel         = '0;
      for (int i = NUM_IRQ - 1; i >= 0; i--) begin
         if (req[i]) sel = 5'(i);
      end
   end

   // dispatch FSM with registered outputs; also owns gie, mask and pending
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         gie_q       <= 1'b0;
         mask_q      <= '0;
         pending_q   <= '0;
         stall_q     <= 1'b0;
         flush_q     <= 1'b0;
         ilr_we_q    <= 1'b0;
         vec_valid_q <= 1'b0;
         vec_pc_q    <= '0;
         in_isr_q    <= 1'b0;
         irq_id_q    <= '0;
      end else begin
         mask_q      <= mask_nxt;
         gie_q       <= gie_nxt;
         pending_q   <= pending_set;
         ilr_we_q    <= 1'b0;
         flush_q     <= 1'b0;
         vec_valid_q <= 1'b0;
         case (state)
            IDLE: begin
               if (req_go) begin
                  state   <= DRAIN;
                  stall_q <= 1'b1;
               end
            end
            DRAIN: begin
               if (!req_go) begin
                  state   <= IDLE;
                  stall_q <= 1'b0;
               end else if (bus.pipe_empty) begin
                  state    <= SAVE;
                  ilr_we_q <= req_go_nxt;
               end
            end
            SAVE: begin
               if (req_go) begin
                  state       <= VECTOR;
                  irq_id_q    <= sel;
                  // the dispatch clear beats a same-cycle set; a held level line re-pends next cycle
                  pending_q   <= pending_set & ~(NUM_IRQ'(1) << sel);
                  // hardware disable wins over a coincident software GIE write: no nesting
                  gie_q       <= 1'b0;
                  flush_q     <= 1'b1;
                  vec_valid_q <= 1'b1;
                  vec_pc_q    <= VEC_BASE + 32'(sel) * VEC_STRIDE;
               end else begin
                  state   <= IDLE;
                  stall_q <= 1'b0;
               end
            end
            VECTOR: begin
               state    <= ISR;
               stall_q  <= 1'b0;
               vec_pc_q <= '0;
               in_isr_q <= 1'b1;
            end
            ISR: begin
               if (bus.rti) begin
                  state    <= IDLE;
                  in_isr_q <= 1'b0;
                  irq_id_q <= '0;
                  gie_q    <= bus.gie_we ? bus.gie_wdata : 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.stall     = stall_q;
   assign bus.flush     = flush_q;
   assign bus.ilr_we    = ilr_we_q;
   assign bus.ilr_wdata = ilr_we_q ? bus.resume_pc : '0;
   assign bus.vec_valid = vec_valid_q;
   assign bus.vec_pc    = vec_pc_q;
   assign bus.in_isr    = in_isr_q;
   assign bus.irq_id    = irq_id_q;
   assign bus.pending   = pending_q;

endmodule

// File: tb/tb_irq_sequencer.sv
// tb_irq_sequencer: scenario tasks plus randomized dispatch trials against a set/queue model
// Latency: n/a
// Backpressure: pipe_empty driven low/randomly to exercise the drain wait
module tb_irq_sequencer;
   localparam int N = 8;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   total = 0;
   int   bad = 0;
   int   cyc = 0;
   int   last_rti_cyc = 0;

   irq_sequencer_if #(.NUM_IRQ(N)) bus ();

   irq_sequencer #(.NUM_IRQ(N), .VEC_BASE(32'h0000_0100), .VEC_STRIDE(32'h0000_0010)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // event log of observed outputs
   logic [31:0] vec_q[$];
   logic [31:0] ilr_q[$];
   int          id_q[$];
   int          vec_cyc_q[$];
   int          ilr_cyc_q[$];
   int          stall_rise_q[$];
   int          isr_rise_q[$];
   int          pend_rise_cyc = -1;
   logic        prev_stall = 1'b0;
   logic        prev_isr = 1'b0;
   logic [N-1:0] prev_pend = '0;

   always @(negedge clk) begin
      if (bus.vec_valid) begin
         vec_q.push_back(bus.vec_pc);
         id_q.push_back(int'(bus.irq_id));
         vec_cyc_q.push_back(cyc);
      end
      if (bus.ilr_we) begin
         ilr_q.push_back(bus.ilr_wdata);
         ilr_cyc_q.push_back(cyc);
      end
      if (bus.stall && !prev_stall) stall_rise_q.push_back(cyc);
      if (bus.in_isr && !prev_isr) isr_rise_q.push_back(cyc);
      if (bus.pending != '0 && prev_pend == '0) pend_rise_cyc = cyc;
      prev_stall = bus.stall;
      prev_isr   = bus.in_isr;
      prev_pend  = bus.pending;
   end

   task automatic clr_mon();
      vec_q.delete(); ilr_q.delete(); id_q.delete(); vec_cyc_q.delete();
      ilr_cyc_q.delete(); stall_rise_q.delete(); isr_rise_q.delete();
      pend_rise_cyc = -1;
   endtask

   task automatic nxt();
      @(negedge clk);
      #1;
   endtask

   task automatic wr_gie(input logic v);
      bus.gie_we = 1'b1; bus.gie_wdata = v;
      nxt();
      bus.gie_we = 1'b0; bus.gie_wdata = 1'b0;
   endtask

   task automatic wr_mask(input logic [N-1:0] v);
      bus.mask_we = 1'b1; bus.mask_wdata = v;
      nxt();
      bus.mask_we = 1'b0; bus.mask_wdata = '0;
   endtask

   task automatic pulse_irq(input logic [N-1:0] v, input int n);
      bus.irq = v;
      repeat (n) nxt();
      bus.irq = '0;
   endtask

   task automatic wait_isr(input int maxc, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < maxc; i++) begin
         if (bus.in_isr) begin ok = 1'b1; break; end
         nxt();
      end
   endtask

   task automatic wait_stall(input int maxc, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < maxc; i++) begin
         if (bus.stall) begin ok = 1'b1; break; end
         nxt();
      end
   endtask

   task automatic do_rti();
      bus.rti = 1'b1;
      last_rti_cyc = cyc;
      nxt();
      bus.rti = 1'b0;
   endtask

   task automatic test_reset();
      bit ok;
      repeat (2) nxt();
      total++;
      if ({bus.stall, bus.flush, bus.ilr_we, bus.vec_valid, bus.in_isr} !== 5'b0) begin
         bad++; $display("FAIL reset_ctrl: got %b want 00000", {bus.stall, bus.flush, bus.ilr_we, bus.vec_valid, bus.in_isr});
      end
      total++;
      if (bus.pending !== '0 || bus.irq_id !== 5'd0 || bus.vec_pc !== 32'd0 || bus.ilr_wdata !== 32'd0) begin
         bad++; $display("FAIL reset_data: pending=%h id=%0d vec=%h ilr=%h want all 0", bus.pending, bus.irq_id, bus.vec_pc, bus.ilr_wdata);
      end
      rst_n = 1'b1;
      nxt();
      wr_gie(1'b1);
      wr_mask(8'h04);
      bus.pipe_empty = 1'b0;
      bus.resume_pc = 32'hDEAD_BEEF;
      pulse_irq(8'h04, 3);
      wait_stall(20, ok);
      total++;
      if (!ok) begin bad++; $display("FAIL reset_reach_drain: stall=%b want 1", bus.stall); end
      repeat (2) nxt();
      rst_n = 1'b0;
      #1;
      total++;
      if ({bus.stall, bus.flush, bus.ilr_we, bus.vec_valid, bus.in_isr} !== 5'b0 || bus.pending !== '0 || bus.ilr_wdata !== 32'd0) begin
         bad++; $display("FAIL reset_mid_drain: ctrl=%b pending=%h ilr=%h want 0", {bus.stall, bus.flush, bus.ilr_we, bus.vec_valid, bus.in_isr}, bus.pending, bus.ilr_wdata);
      end
      nxt();
      rst_n = 1'b1;
      clr_mon();
      bus.pipe_empty = 1'b1;
      repeat (10) nxt();
      total++;
      if (ilr_q.size() != 0 || vec_q.size() != 0 || bus.stall !== 1'b0) begin
         bad++; $display("FAIL reset_no_side_effects: ilr=%0d vec=%0d stall=%b want 0 0 0", ilr_q.size(), vec_q.size(), bus.stall);
      end
   endtask

   task automatic test_single();
      bit ok;
      wr_gie(1'b1);
      wr_mask(8'h04);
      bus.pipe_empty = 1'b1;
      bus.resume_pc = 32'h0000_2040;
      clr_mon();
      pulse_irq(8'h04, 3);
      wait_isr(30, ok);
      total++;
      if (!ok) begin bad++; $display("FAIL single_isr_timeout: in_isr=%b want 1", bus.in_isr); end
      total++;
      if (ilr_q.size() != 1 || ilr_q[0] !== 32'h0000_2040) begin
         bad++; $display("FAIL single_ilr: n=%0d val=%h want 1 00002040", ilr_q.size(), ilr_q[0]);
      end
      total++;
      if (vec_q.size() != 1 || vec_q[0] !== 32'h0000_0120 || id_q[0] != 2) begin
         bad++; $display("FAIL single_vec: n=%0d pc=%h id=%0d want 1 00000120 2", vec_q.size(), vec_q[0], id_q[0]);
      end
      total++;
      if (bus.pending[2] !== 1'b0 || bus.irq_id !== 5'd2) begin
         bad++; $display("FAIL single_state: pending2=%b id=%0d want 0 2", bus.pending[2], bus.irq_id);
      end
      total++;
      if (stall_rise_q[0] - pend_rise_cyc != 1 || ilr_cyc_q[0] - pend_rise_cyc != 2 ||
          vec_cyc_q[0] - pend_rise_cyc != 3 || isr_rise_q[0] - pend_rise_cyc != 4) begin
         bad++; $display("FAIL single_latency: stall+%0d ilr+%0d vec+%0d isr+%0d want +1 +2 +3 +4",
            stall_rise_q[0] - pend_rise_cyc, ilr_cyc_q[0] - pend_rise_cyc, vec_cyc_q[0] - pend_rise_cyc, isr_rise_q[0] - pend_rise_cyc);
      end
      do_rti();
      total++;
      if (bus.in_isr !== 1'b0 || bus.irq_id !== 5'd0) begin
         bad++; $display("FAIL single_rti: in_isr=%b id=%0d want 0 0", bus.in_isr, bus.irq_id);
      end
   endtask

   task automatic test_priority();
      bit ok;
      int r;
      wr_mask(8'hFF);
      clr_mon();
      pulse_irq(8'h22, 3);
      wait_isr(30, ok);
      total++;
      if (!ok || vec_q.size() != 1 || vec_q[0] !== 32'h0000_0110) begin
         bad++; $display("FAIL prio_first: ok=%b n=%0d pc=%h want 1 1 00000110", ok, vec_q.size(), vec_q[0]);
      end
      total++;
      if (bus.pending[5] !== 1'b1) begin bad++; $display("FAIL prio_pending5: got %b want 1", bus.pending[5]); end
      do_rti();
      r = last_rti_cyc;
      wait_isr(30, ok);
      total++;
      if (!ok || vec_q.size() != 2 || vec_q[1] !== 32'h0000_0150) begin
         bad++; $display("FAIL prio_second: ok=%b n=%0d pc=%h want 1 2 00000150", ok, vec_q.size(), vec_q[1]);
      end
      total++;
      if (stall_rise_q.size() != 2 || stall_rise_q[1] - r != 2) begin
         bad++; $display("FAIL prio_gap: rises=%0d rti_to_stall=%0d want 2 2", stall_rise_q.size(), stall_rise_q[1] - r);
      end
      do_rti();
   endtask

   task automatic test_drain_wait();
      bit ok;
      int held;
      wr_mask(8'h08);
      bus.pipe_empty = 1'b0;
      clr_mon();
      pulse_irq(8'h08, 3);
      wait_stall(20, ok);
      total++;
      if (!ok) begin bad++; $display("FAIL drain_stall_timeout: stall=%b want 1", bus.stall); end
      held = 0;
      for (int i = 0; i < 6; i++) begin
         if (bus.stall) held++;
         nxt();
      end
      total++;
      if (held != 6 || ilr_q.size() != 0) begin
         bad++; $display("FAIL drain_hold: stall_cycles=%0d ilr=%0d want 6 0", held, ilr_q.size());
      end
      bus.pipe_empty = 1'b1;
      wait_isr(20, ok);
      total++;
      if (!ok || ilr_q.size() != 1 || vec_q.size() != 1 || vec_q[0] !== 32'h0000_0130) begin
         bad++; $display("FAIL drain_release: ok=%b ilr=%0d vec=%0d pc=%h want 1 1 1 00000130", ok, ilr_q.size(), vec_q.size(), vec_q[0]);
      end
      do_rti();
   endtask

   task automatic test_abort();
      bit ok;
      wr_mask(8'hFF);
      bus.pipe_empty = 1'b0;
      clr_mon();
      pulse_irq(8'h40, 3);
      wait_stall(20, ok);
      total++;
      if (!ok) begin bad++; $display("FAIL abort_stall_timeout: stall=%b want 1", bus.stall); end
      wr_mask(8'h00);
      repeat (3) nxt();
      total++;
      if (bus.stall !== 1'b0 || ilr_q.size() != 0 || vec_q.size() != 0) begin
         bad++; $display("FAIL abort_idle: stall=%b ilr=%0d vec=%0d want 0 0 0", bus.stall, ilr_q.size(), vec_q.size());
      end
      total++;
      if (bus.pending !== 8'h40) begin bad++; $display("FAIL abort_pending: got %h want 40", bus.pending); end
      wr_mask(8'h40);
      bus.pipe_empty = 1'b1;
      wait_isr(30, ok);
      total++;
      if (!ok || vec_q.size() != 1 || vec_q[0] !== 32'h0000_0160) begin
         bad++; $display("FAIL abort_redispatch: ok=%b n=%0d pc=%h want 1 1 00000160", ok, vec_q.size(), vec_q[0]);
      end
      do_rti();
   endtask

   logic [31:0] exp_ilr[$];
   int          exp_ids[$];

   task automatic test_random();
      logic [N-1:0] model_pend, all_p, msk, pls;
      int idle_run;
      model_pend = '0;
      for (int t = 0; t < 12; t++) begin
         msk = N'($urandom);
         pls = N'($urandom);
         if (pls == '0) pls = 8'h01;
         wr_gie(1'b0);
         wr_mask(msk);
         exp_ilr.delete();
         exp_ids.delete();
         bus.resume_pc = $urandom;
         exp_ilr.push_back(bus.resume_pc);
         pulse_irq(pls, 3);
         repeat (3) nxt();
         // everything is pending before GIE opens, so service order is plain ascending index
         all_p = model_pend | pls;
         for (int i = 0; i < N; i++) if (all_p[i] && msk[i]) exp_ids.push_back(i);
         model_pend = all_p & ~msk;
         clr_mon();
         wr_gie(1'b1);
         idle_run = 0;
         for (int c = 0; c < 400 && idle_run < 8; c++) begin
            bus.pipe_empty = ($urandom % 3) != 0;
            if (bus.in_isr && ($urandom % 3) == 0) begin
               bus.rti = 1'b1;
               bus.resume_pc = $urandom;
               exp_ilr.push_back(bus.resume_pc);
            end else begin
               bus.rti = 1'b0;
            end
            if (!bus.stall && !bus.in_isr && vec_q.size() == exp_ids.size()) idle_run++;
            else idle_run = 0;
            nxt();
         end
         bus.rti = 1'b0;
         bus.pipe_empty = 1'b1;
         total++;
         if (vec_q.size() != exp_ids.size() || ilr_q.size() != exp_ids.size()) begin
            bad++; $display("FAIL rand_count t%0d: vec=%0d ilr=%0d want %0d", t, vec_q.size(), ilr_q.size(), exp_ids.size());
         end
         for (int k = 0; k < exp_ids.size() && k < vec_q.size() && k < ilr_q.size(); k++) begin
            total++;
            if (vec_q[k] !== 32'h0000_0100 + 32'(exp_ids[k]) * 32'h10 || id_q[k] != exp_ids[k] || ilr_q[k] !== exp_ilr[k]) begin
               bad++; $display("FAIL rand_dispatch t%0d k%0d: pc=%h id=%0d ilr=%h want pc for id %0d ilr=%h",
                  t, k, vec_q[k], id_q[k], ilr_q[k], exp_ids[k], exp_ilr[k]);
            end
         end
         total++;
         if (bus.pending !== model_pend) begin
            bad++; $display("FAIL rand_pending t%0d: got %h want %h", t, bus.pending, model_pend);
         end
      end
   endtask

   task automatic test_edge_level();
      bit ok;
      int exp_n;
      logic exp_p0;
`ifdef IRQ_EDGE_EN
      exp_n = 1; exp_p0 = 1'b0;
`else
      exp_n = 2; exp_p0 = 1'b1;
`endif
      wr_gie(1'b1);
      wr_mask(8'h01);
      bus.pipe_empty = 1'b1;
      clr_mon();
      bus.irq = 8'h01;
      wait_isr(30, ok);
      total++;
      if (!ok) begin bad++; $display("FAIL edge_first_timeout: in_isr=%b want 1", bus.in_isr); end
      repeat (3) nxt();
      total++;
      if (bus.pending[0] !== exp_p0) begin bad++; $display("FAIL edge_repend: pending0=%b want %b", bus.pending[0], exp_p0); end
      do_rti();
      repeat (15) nxt();
      total++;
      if (vec_q.size() != exp_n) begin bad++; $display("FAIL edge_dispatch_count: got %0d want %0d", vec_q.size(), exp_n); end
      bus.irq = '0;
      if (bus.in_isr) do_rti();
   endtask

   initial begin
      bus.irq = '0; bus.gie_we = 1'b0; bus.gie_wdata = 1'b0;
      bus.mask_we = 1'b0; bus.mask_wdata = '0; bus.pipe_empty = 1'b1;
      bus.resume_pc = '0; bus.rti = 1'b0;
      test_reset();
      test_single();
      test_priority();
      test_drain_wait();
      test_abort();
      test_random();
      test_edge_level();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/irq_sequencer.md
Name: irq_sequencer

Overview:
- Interrupt controller and sequencer for the decode stage.
- Synchronises and latches external interrupt requests, then picks the highest-priority enabled one.
- Stalls the pipeline until it drains, then saves the resume PC into ILR (register 31) through a dedicated write request.
- Redirects fetch to a vector address, and returns to idle when the decode stage reports an RTI instruction.

Parameters:
- NUM_IRQ, 8, number of interrupt request lines (1..32); index 0 is highest priority.
- VEC_BASE, 32'h0000_0100, vector address of IRQ 0.
- VEC_STRIDE, 32'h0000_0010, byte distance between consecutive vectors.

Ports:
- clk  input  1  system clock, all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- irq  input  NUM_IRQ  raw request lines, asynchronous to clk
- gie_we  input  1  global-interrupt-enable write strobe
- gie_wdata  input  1  new GIE value
- mask_we  input  1  mask register write strobe
- mask_wdata  input  NUM_IRQ  new mask value (1 = enabled)
- pipe_empty  input  1  no instruction in flight past decode
- resume_pc  input  32  PC of the next instruction to execute after return
- rti  input  1  decode has an RTI instruction this cycle
- stall  output  1  hold fetch/decode
- flush  output  1  discard the fetch/decode contents
- ilr_we  output  1  write ILR (r31)
- ilr_wdata  output  32  value for ILR
- vec_valid  output  1  load vec_pc into PC
- vec_pc  output  32  vector target
- in_isr  output  1  handler is executing
- irq_id  output  5  ID of the IRQ being serviced
- pending  output  NUM_IRQ  pending register

Behaviour:
- Reset (asynchronous, rst_n low):
  - All outputs 0; gie=0; mask=0; pending=0; synchronisers=0; state=IDLE.
  - Reset asserted mid-sequence aborts immediately; no ILR write or vector is issued afterwards.
- Synchronisation: each irq bit passes through a 2-flop synchroniser (sirq).
  - Latency from an irq change to pending is 2 cycles, plus 1 in edge mode.
- Pending (level mode): pending[i] set each cycle sirq[i]=1; cleared only when IRQ i is dispatched in SAVE.
- Selection: req = pending & mask; sel = lowest set index of req.
- Register writes:
  - gie and mask take effect on the next cycle.
  - A write in the same cycle as a dispatch decision does not affect that cycle's decision.
- FSM states: IDLE, DRAIN, SAVE, VECTOR, ISR.
  - IDLE:
    - if gie && |req, go to DRAIN; stall rises on the next cycle.
    - rti is ignored.
  - DRAIN:
    - stall=1.
    - if pipe_empty, go to SAVE.
    - if req becomes 0 (masked/GIE cleared) before pipe_empty, go back to IDLE with no side effects.
  - SAVE (1 cycle):
    - stall=1, ilr_we=1, ilr_wdata=resume_pc.
    - latch irq_id=sel; clear pending[sel]; clear gie.
    - next state VECTOR.
    - if req==0 in SAVE: ilr_we=0, go to IDLE.
  - VECTOR (1 cycle):
    - stall=1, flush=1, vec_valid=1.
    - vec_pc = VEC_BASE + irq_id*VEC_STRIDE, computed modulo 2^32.
    - next state ISR.
  - ISR:
    - stall=0, in_isr=1.
    - new requests only accumulate in pending (no nesting).
    - on rti, go to IDLE and set gie=1, irq_id=0.
    - if rti and gie_we coincide, gie_we wins.
- Minimum gap: one IDLE cycle between RTI and the next DRAIN.
- Dispatch latency: for an IRQ pending in IDLE with pipe_empty=1, the outputs are:
  - stall high 1 cycle later;
  - SAVE at +2;
  - VECTOR at +3;
  - ISR at +4.
- Bounds: irq_id is zero-extended to 5 bits; bits of mask_wdata above NUM_IRQ are ignored.

Optional Feature:
- Macro IRQ_EDGE_EN.
- Defined: pending[i] sets only on a 0->1 transition of sirq[i] (one extra register stage); a held-high line raises exactly one interrupt.
- Undefined: level mode as described above; a line still high after dispatch re-pends on the next cycle.

Test Plan:
- Reset: drive rst_n=0 mid-DRAIN -> all outputs 0, state IDLE, no ilr_we afterwards.
- Single dispatch:
  - Stimulus: gie=1, mask=8'h04, irq[2] pulse 3 cycles, pipe_empty=1, resume_pc=32'h0000_2040.
  - Required: ilr_we with ilr_wdata=32'h0000_2040; vec_valid with vec_pc=32'h0000_0120; in_isr=1; pending[2]=0.
- Priority:
  - Stimulus: irq[5] and irq[1] together, mask=8'hFF.
  - Required: vec_pc=32'h0000_0110 first; after rti, vec_pc=32'h0000_0150 is dispatched with exactly one IDLE cycle between.
- Drain wait:
  - Stimulus: pipe_empty=0 for 5 cycles.
  - Required: stall held 5+ cycles, no ilr_we until pipe_empty=1.
- Abort: mask write to 0 during DRAIN -> return to IDLE, stall drops, no ilr_we or vec_valid.
- Edge vs level: hold irq[0]=1 through the handler and rti.
  - Without IRQ_EDGE_EN: a second dispatch occurs.
  - With IRQ_EDGE_EN: no second dispatch.
